// File: rtl/list_stream_harness_if.sv
// Producer-side handshake bundle between the harness and a list-producing dataflow DUT.
interface list_stream_harness_if #(
  parameter int DATA_W = 8
) ();
  logic              dut_start;
  logic              dut_done;
  logic              list_req;
  logic              list_ack;
  logic [DATA_W-1:0] list_value;
  logic              list_value_valid;

  modport master (
    output dut_start, list_req,
    input  dut_done, list_ack, list_value, list_value_valid
  );

  modport slave (
    input  dut_start, list_req,
    output dut_done, list_ack, list_value, list_value_valid
  );
endinterface

// File: rtl/list_stream_harness.sv
// Periodic run launcher for a list-producing DUT: paces req/ack pulls, accumulates
// count and checksum, flags timeout/overflow/protocol errors and reports on LED.
module list_stream_harness #(
  parameter int DATA_W    = 8,
  parameter int PERIOD_W  = 25,
  parameter int GAP       = 10,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_ELEMS = 255
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [1:0]           KEY,
  list_stream_harness_if.master bus,
  output logic [7:0]           elem_count,
  output logic [DATA_W-1:0]    checksum,
  output logic [1:0]           status,
  output logic [7:0]           run_count,
  output logic [7:0]           LED
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_GAP, S_DRAIN, S_REPORT} state_t;

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [8:0]        GAP_L     = 9'(GAP);
  localparam logic [7:0]        MAX_L     = 8'(MAX_ELEMS);
  localparam logic [1:0]        ST_OK = 2'b00, ST_TIMEOUT = 2'b01,
                                ST_OVERFLOW = 2'b10, ST_PROTO = 2'b11;

  state_t              state_q;
  logic [PERIOD_W-1:0] timer_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [7:0]          gap_q;
  logic [7:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                dut_start_q, list_req_q;
  logic [7:0]          elem_count_q, run_count_q;
  logic [DATA_W-1:0]   checksum_q;
  logic [1:0]          status_q;
  logic                fin;
  logic [1:0]          fin_status;

  assign cnt_d = cnt_q + 8'd1;
  assign sum_d = sum_q + bus.list_value;

  // Every run termination funnels through here so the summary latch is in one place.
  always_comb begin
    fin        = 1'b0;
    fin_status = ST_OK;
    unique case (state_q)
      S_REQ: begin
        if (bus.list_ack) begin
          if (bus.list_value_valid && !(cnt_q < MAX_L)) begin
            fin        = 1'b1;
            fin_status = ST_OVERFLOW;
          end
        end else if (wait_q == WAIT_LAST) begin
          fin        = 1'b1;
          fin_status = ST_TIMEOUT;
        end
      end
      S_GAP: begin
        if (bus.list_ack) begin
          fin        = 1'b1;
          fin_status = ST_PROTO;
        end
      end
      S_DRAIN: begin
        if (bus.list_ack) begin
          fin        = 1'b1;
          fin_status = ST_PROTO;
        end else if (bus.dut_done) begin
          fin        = 1'b1;
          fin_status = ST_OK;
        end else if (wait_q == WAIT_LAST) begin
          fin        = 1'b1;
          fin_status = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      wait_q       <= '0;
      gap_q        <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      dut_start_q  <= 1'b0;
      list_req_q   <= 1'b0;
      elem_count_q <= '0;
      checksum_q   <= '0;
      status_q     <= '0;
      run_count_q  <= '0;
    end else begin
      timer_q <= timer_q + PERIOD_W'(1);
      if (fin) begin
        state_q      <= S_REPORT;
        dut_start_q  <= 1'b0;
        list_req_q   <= 1'b0;
        elem_count_q <= cnt_q;
        checksum_q   <= sum_q;
        status_q     <= fin_status;
        run_count_q  <= run_count_q + 8'd1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (timer_q == '0 && KEY[0]) begin
              state_q     <= S_REQ;
              dut_start_q <= 1'b1;
              list_req_q  <= 1'b1;
              cnt_q       <= '0;
              sum_q       <= '0;
              wait_q      <= '0;
            end
          end
          S_REQ: begin
            if (bus.list_ack) begin
              list_req_q <= 1'b0;
              wait_q     <= '0;
              if (bus.list_value_valid) begin
                cnt_q   <= cnt_d;
                sum_q   <= sum_d;
                gap_q   <= '0;
                state_q <= S_GAP;
              end else begin
                state_q <= S_DRAIN;
              end
            end else begin
              wait_q <= wait_q + WAIT_W'(1);
            end
          end
          S_GAP: begin
            // GAP=0 still spends this one cycle here, giving the minimum one-cycle low req.
            if (({1'b0, gap_q} + 9'd1) >= GAP_L) begin
              list_req_q <= 1'b1;
              wait_q     <= '0;
              state_q    <= S_REQ;
            end else begin
              gap_q <= gap_q + 8'd1;
            end
          end
          S_DRAIN:  wait_q  <= wait_q + WAIT_W'(1);
          S_REPORT: state_q <= S_IDLE;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.dut_start = dut_start_q;
  assign bus.list_req  = list_req_q;
  assign elem_count    = elem_count_q;
  assign checksum      = checksum_q;
  assign status        = status_q;
  assign run_count     = run_count_q;
  assign LED           = KEY[1] ? elem_count_q : {status_q, run_count_q[5:0]};
endmodule

// File: tb/tb_list_stream_harness.sv
// Directed bench: u0 (GAP=2, TIMEOUT=16, MAX_ELEMS=4) and u1 (GAP=0) driven by one paced producer.
module tb_list_stream_harness;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] key0_b, key1_b;
  logic       sel;
  logic       ack_b, valid_b, done_b;
  logic [7:0] value_b;
  int         vectors = 0;
  int         miscompares = 0;

  list_stream_harness_if #(.DATA_W(8)) if0 ();
  list_stream_harness_if #(.DATA_W(8)) if1 ();

  assign if0.list_ack         = ack_b & ~sel;
  assign if0.dut_done         = done_b & ~sel;
  assign if0.list_value       = value_b;
  assign if0.list_value_valid = valid_b;
  assign if1.list_ack         = ack_b & sel;
  assign if1.dut_done         = done_b & sel;
  assign if1.list_value       = value_b;
  assign if1.list_value_valid = valid_b;

  logic [7:0] ec0, cs0, rc0, led0, ec1, cs1, rc1, led1;
  logic [1:0] st0, st1;

  list_stream_harness #(.DATA_W(8), .PERIOD_W(6), .GAP(2), .TIMEOUT(16), .MAX_ELEMS(4)) u0 (
    .CLOCK_50(clk), .reset(rst), .KEY(key0_b), .bus(if0.master),
    .elem_count(ec0), .checksum(cs0), .status(st0), .run_count(rc0), .LED(led0)
  );
  list_stream_harness #(.DATA_W(8), .PERIOD_W(6), .GAP(0), .TIMEOUT(16), .MAX_ELEMS(255)) u1 (
    .CLOCK_50(clk), .reset(rst), .KEY(key1_b), .bus(if1.master),
    .elem_count(ec1), .checksum(cs1), .status(st1), .run_count(rc1), .LED(led1)
  );

  logic       m_start, m_req;
  logic [7:0] m_ec, m_cs, m_rc, m_led;
  logic [1:0] m_st;
  assign m_start = sel ? if1.dut_start : if0.dut_start;
  assign m_req   = sel ? if1.list_req  : if0.list_req;
  assign m_ec    = sel ? ec1  : ec0;
  assign m_cs    = sel ? cs1  : cs0;
  assign m_rc    = sel ? rc1  : rc0;
  assign m_led   = sel ? led1 : led0;
  assign m_st    = sel ? st1  : st0;

  task automatic wait_start(output bit ok);
    int n = 0;
    while (m_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (m_start === 1'b1);
  endtask

  // Waits for req, acks in the same cycle, returns how many cycles req was seen low first.
  task automatic serve(input logic [7:0] v, input logic vld, output int low, output bit ok);
    low = 0;
    while (m_req !== 1'b1 && low < 64) begin
      @(negedge clk);
      low++;
    end
    ok = (m_req === 1'b1);
    if (ok) begin
      ack_b   = 1'b1;
      valid_b = vld;
      value_b = v;
      @(negedge clk);
      ack_b   = 1'b0;
      valid_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if ({if0.dut_start, if0.list_req, if1.dut_start, if1.list_req} !== 4'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b, expected 0000", {if0.dut_start, if0.list_req, if1.dut_start, if1.list_req});
    end
    vectors++; if ({ec0, cs0, st0, rc0, led0} !== 34'd0) begin
      miscompares++; $display("FAIL reset_outputs: got %h, expected 0", {ec0, cs0, st0, rc0, led0});
    end
    key0_b = 2'b11;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok; int low;
    logic [7:0] vals [3] = '{8'd3, 8'd5, 8'd7};
    wait_start(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL basic_start: got no dut_start, expected rise"); end
    for (int unsigned i = 0; i < 3; i++) begin
      serve(vals[i], 1'b1, low, ok);
      vectors++; if (!ok || low != (i == 0 ? 0 : 2)) begin
        miscompares++; $display("FAIL basic_gap[%0d]: got low=%0d ok=%0b, expected low=%0d", i, low, ok, (i == 0 ? 0 : 2));
      end
      vectors++; if (m_req !== 1'b0) begin miscompares++; $display("FAIL basic_req_pulse[%0d]: got %b, expected 0", i, m_req); end
    end
    serve(8'd0, 1'b0, low, ok);
    vectors++; if (!ok || low != 2) begin miscompares++; $display("FAIL basic_end_gap: got %0d, expected 2", low); end
    done_b = 1'b1;
    @(negedge clk);
    done_b = 1'b0;
    vectors++; if ({m_start, m_ec, m_cs, m_st, m_rc} !== {1'b0, 8'd3, 8'd15, 2'b00, 8'd1}) begin
      miscompares++; $display("FAIL basic_report: got start=%b ec=%0d cs=%0d st=%b rc=%0d, expected 0 3 15 00 1", m_start, m_ec, m_cs, m_st, m_rc);
    end
    vectors++; if (m_led !== 8'd3) begin miscompares++; $display("FAIL led_count_view: got %0d, expected 3", m_led); end
    key0_b = 2'b01; #1;
    vectors++; if (m_led !== 8'h01) begin miscompares++; $display("FAIL led_status_view: got %h, expected 01", m_led); end
    key0_b = 2'b11;
  endtask

  task automatic test_checksum_wrap();
    bit ok; int low;
    wait_start(ok);
    serve(8'd200, 1'b1, low, ok);
    serve(8'd100, 1'b1, low, ok);
    serve(8'd0, 1'b0, low, ok);
    done_b = 1'b1;
    @(negedge clk);
    done_b = 1'b0;
    vectors++; if ({m_ec, m_cs, m_st, m_rc} !== {8'd2, 8'd44, 2'b00, 8'd2}) begin
      miscompares++; $display("FAIL checksum_wrap: got ec=%0d cs=%0d st=%b rc=%0d, expected 2 44 00 2", m_ec, m_cs, m_st, m_rc);
    end
  endtask

  task automatic test_overflow();
    bit ok; int low;
    wait_start(ok);
    for (int unsigned i = 1; i <= 5; i++) serve(8'(i), 1'b1, low, ok);
    vectors++; if ({m_start, m_ec, m_cs, m_st, m_rc} !== {1'b0, 8'd4, 8'd10, 2'b10, 8'd3}) begin
      miscompares++; $display("FAIL overflow: got start=%b ec=%0d cs=%0d st=%b rc=%0d, expected 0 4 10 10 3", m_start, m_ec, m_cs, m_st, m_rc);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    wait_start(ok);
    repeat (15) @(negedge clk);
    vectors++; if ({m_start, m_req, m_st} !== {1'b1, 1'b1, 2'b10}) begin
      miscompares++; $display("FAIL timeout_cycle16: got start=%b req=%b st=%b, expected 1 1 10", m_start, m_req, m_st);
    end
    @(negedge clk);
    vectors++; if ({m_start, m_req, m_ec, m_st, m_rc} !== {1'b0, 1'b0, 8'd0, 2'b01, 8'd4}) begin
      miscompares++; $display("FAIL timeout_report: got start=%b req=%b ec=%0d st=%b rc=%0d, expected 0 0 0 01 4", m_start, m_req, m_ec, m_st, m_rc);
    end
  endtask

  task automatic test_protocol();
    bit ok; int low;
    wait_start(ok);
    serve(8'd9, 1'b1, low, ok);
    ack_b = 1'b1;
    @(negedge clk);
    ack_b = 1'b0;
    vectors++; if ({m_start, m_ec, m_cs, m_st, m_rc} !== {1'b0, 8'd1, 8'd9, 2'b11, 8'd5}) begin
      miscompares++; $display("FAIL protocol: got start=%b ec=%0d cs=%0d st=%b rc=%0d, expected 0 1 9 11 5", m_start, m_ec, m_cs, m_st, m_rc);
    end
    key0_b = 2'b10;
  endtask

  task automatic test_key_inhibit();
    bit seen = 1'b0;
    repeat (140) begin
      @(negedge clk);
      if (m_start === 1'b1) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0 || m_rc !== 8'd5) begin
      miscompares++; $display("FAIL key_inhibit: got start_seen=%b rc=%0d, expected 0 5", seen, m_rc);
    end
  endtask

  task automatic test_reset_midrun();
    bit ok; int low;
    key0_b = 2'b11;
    wait_start(ok);
    @(negedge clk);
    rst = 1'b1; #1;
    vectors++; if ({m_start, m_req, m_ec, m_cs, m_st, m_rc, m_led} !== 36'd0) begin
      miscompares++; $display("FAIL reset_midrun: got %h, expected 0", {m_start, m_req, m_ec, m_cs, m_st, m_rc, m_led});
    end
    @(negedge clk);
    rst = 1'b0;
    wait_start(ok);
    vectors++; if (!ok || m_req !== 1'b1 || m_rc !== 8'd0) begin
      miscompares++; $display("FAIL fresh_run_start: got ok=%b req=%b rc=%0d, expected 1 1 0", ok, m_req, m_rc);
    end
    serve(8'd0, 1'b0, low, ok);
    done_b = 1'b1;
    @(negedge clk);
    done_b = 1'b0;
    vectors++; if ({m_ec, m_cs, m_st, m_rc} !== {8'd0, 8'd0, 2'b00, 8'd1}) begin
      miscompares++; $display("FAIL fresh_run_report: got ec=%0d cs=%0d st=%b rc=%0d, expected 0 0 00 1", m_ec, m_cs, m_st, m_rc);
    end
    key0_b = 2'b10;
  endtask

  task automatic test_back_to_back();
    bit ok; int low;
    sel    = 1'b1;
    key1_b = 2'b11;
    wait_start(ok);
    for (int unsigned i = 1; i <= 3; i++) begin
      serve(8'(i), 1'b1, low, ok);
      vectors++; if (!ok || low != (i == 1 ? 0 : 1)) begin
        miscompares++; $display("FAIL gap0[%0d]: got low=%0d ok=%0b, expected low=%0d", i, low, ok, (i == 1 ? 0 : 1));
      end
    end
    serve(8'd0, 1'b0, low, ok);
    done_b = 1'b1;
    @(negedge clk);
    done_b = 1'b0;
    vectors++; if ({m_ec, m_cs, m_st, m_rc} !== {8'd3, 8'd6, 2'b00, 8'd1}) begin
      miscompares++; $display("FAIL gap0_report: got ec=%0d cs=%0d st=%b rc=%0d, expected 3 6 00 1", m_ec, m_cs, m_st, m_rc);
    end
  endtask

  initial begin
    rst = 1'b1; key0_b = 2'b00; key1_b = 2'b00; sel = 1'b0;
    ack_b = 1'b0; valid_b = 1'b0; done_b = 1'b0; value_b = 8'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_checksum_wrap();
    test_overflow();
    test_timeout();
    test_protocol();
    test_key_inhibit();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000, expected finish");
    $fatal(1);
  end
endmodule
